// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and the
// default pipeline depth.
package pipe_ctrl_pkg;

    localparam int NSTAGE_DEFAULT = 5;

    typedef enum logic [2:0] {
        ST_FILL   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HALTED = 3'd3,
        ST_STEP   = 3'd4
    } state_e;

endpackage

// File: rtl/pipe_valid_track.sv
// Tracks which pipeline stages beyond IF hold a real instruction and counts
// instructions leaving WB.
module pipe_valid_track (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifid_we,
    input  logic        ifid_flush,
    input  logic        idex_flush,
    output logic [3:0]  valid,
    output logic [31:0] retire_cnt
);

    logic        v_id_q, v_ex_q, v_mem_q, v_wb_q;
    logic        v_id_d, v_ex_d, v_mem_d, v_wb_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        v_id_d       = ifid_we ? !ifid_flush : v_id_q;
        v_ex_d       = v_id_q && !idex_flush;
        v_mem_d      = v_ex_q;
        v_wb_d       = v_mem_q;
        retire_cnt_d = v_wb_q ? retire_cnt_q + 32'd1 : retire_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_id_q       <= 1'b0;
            v_ex_q       <= 1'b0;
            v_mem_q      <= 1'b0;
            v_wb_q       <= 1'b0;
            retire_cnt_q <= 32'd0;
        end else begin
            v_id_q       <= v_id_d;
            v_ex_q       <= v_ex_d;
            v_mem_q      <= v_mem_d;
            v_wb_q       <= v_wb_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign valid      = {v_wb_q, v_mem_q, v_ex_q, v_id_q};
    assign retire_cnt = retire_cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Run/step/halt controller for a 5-stage pipeline: fill sequencing, hazard
// stall/flush decode, breakpoint halting and drain-to-empty.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int NSTAGE = NSTAGE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc,
    input  logic              load_use,
    input  logic              jump_taken,
    output logic [NSTAGE-1:0] stage_en,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              halted,
    output logic [2:0]        state,
    output logic [31:0]       retire_cnt
);

    state_e            state_q, state_d;
    logic [NSTAGE-1:0] stage_en_q, stage_en_d;
    logic              pending_q, pending_d;
    logic              bp_skip_q, bp_skip_d;
    logic              halted_q, halted_d;
    logic [3:0]        valid;
    logic              bp_hit, stop_req;

    assign bp_hit   = bp_en && (pc == bp_addr) && !bp_skip_q;
    assign stop_req = halt_req || bp_hit;

    // A redirect always wins the PC; a stop only blocks sequential fetch.
    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b0;
        case (state_q)
            ST_FILL: idex_flush = 1'b1;
            ST_RUN, ST_STEP: begin
                pc_we      = 1'b1;
                ifid_flush = 1'b0;
                if (jump_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end
                if (state_q == ST_RUN && stop_req) begin
                    pc_we      = jump_taken;
                    ifid_flush = 1'b1;
                end
            end
            ST_DRAIN: begin
                pc_we      = jump_taken;
                ifid_we    = jump_taken || !load_use;
                idex_flush = jump_taken || load_use;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        stage_en_d = stage_en_q;
        pending_d  = pending_q;
        bp_skip_d  = bp_skip_q;
        case (state_q)
            ST_FILL: begin
                stage_en_d = {stage_en_q[NSTAGE-2:0], 1'b1};
                pending_d  = pending_q || halt_req;
                if (stage_en_d == '1) begin
                    state_d   = pending_d ? ST_DRAIN : ST_RUN;
                    pending_d = 1'b0;
                end
            end
            ST_RUN: begin
                bp_skip_d = 1'b0;
                if (stop_req) state_d = ST_DRAIN;
            end
            ST_STEP: begin
                bp_skip_d = 1'b0;
                if (!load_use || jump_taken) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (valid == 4'b0 && !jump_taken) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (run_req) begin
                    state_d   = ST_RUN;
                    bp_skip_d = 1'b1;
                end else if (step_req) begin
                    state_d   = ST_STEP;
                    bp_skip_d = 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_FILL;
            stage_en_q <= '0;
            pending_q  <= 1'b0;
            bp_skip_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_en_q <= stage_en_d;
            pending_q  <= pending_d;
            bp_skip_q  <= bp_skip_d;
            halted_q   <= halted_d;
        end
    end

    pipe_valid_track u_valid (
        .clk        (clk),
        .rst        (rst),
        .ifid_we    (ifid_we),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .valid      (valid),
        .retire_cnt (retire_cnt)
    );

    assign stage_en = stage_en_q;
    assign halted   = halted_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a behavioural pipeline model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int NSTAGE = 5;

    logic              clk;
    logic              rst;
    logic              run_req, step_req, halt_req, bp_en, load_use, jump_taken;
    logic [31:0]       bp_addr, pc_r, jmp_tgt, pc_mask;
    logic [NSTAGE-1:0] stage_en;
    logic              pc_we, ifid_we, ifid_flush, idex_flush, halted;
    logic [2:0]        state;
    logic [31:0]       retire_cnt;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_q[$];

    // behavioural model
    state_e      m_mode;
    int          m_fill;
    bit          m_pend, m_skip;
    bit          m_pipe [4];
    logic [31:0] m_retire;

    logic obs_pc_we, obs_ifid_flush, obs_idex_flush;
    logic [2:0] obs_state;

    pipe_ctrl #(.PC_W(32), .NSTAGE(NSTAGE)) dut (
        .clk        (clk),
        .rst        (rst),
        .run_req    (run_req),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc_r),
        .load_use   (load_use),
        .jump_taken (jump_taken),
        .stage_en   (stage_en),
        .pc_we      (pc_we),
        .ifid_we    (ifid_we),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .halted     (halted),
        .state      (state),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = ST_FILL;
        m_fill   = 0;
        m_pend   = 0;
        m_skip   = 0;
        m_retire = 32'd0;
        for (int i = 0; i < 4; i++) m_pipe[i] = 0;
    endtask

    task automatic model_update(input bit stop, input bit e_we, input bit e_iflush, input bit e_xflush);
        bit empty;
        bit nid;
        if (!rst) begin
            model_reset();
            return;
        end
        empty = !(m_pipe[0] || m_pipe[1] || m_pipe[2] || m_pipe[3]);
        if (m_pipe[3]) m_retire = m_retire + 32'd1;
        nid       = e_we ? !e_iflush : m_pipe[0];
        m_pipe[3] = m_pipe[2];
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0] && !e_xflush;
        m_pipe[0] = nid;
        case (m_mode)
            ST_FILL: begin
                m_fill++;
                if (m_fill == NSTAGE) begin
                    m_mode = (m_pend || halt_req) ? ST_DRAIN : ST_RUN;
                    m_pend = 0;
                end else begin
                    m_pend = m_pend || halt_req;
                end
            end
            ST_RUN: begin
                if (stop) m_mode = ST_DRAIN;
                m_skip = 0;
            end
            ST_STEP: begin
                if (!load_use || jump_taken) m_mode = ST_DRAIN;
                m_skip = 0;
            end
            ST_DRAIN: if (empty && !jump_taken) m_mode = ST_HALTED;
            default: begin
                if (!halt_req && run_req) begin
                    m_mode = ST_RUN;
                    m_skip = 1;
                end else if (!halt_req && step_req) begin
                    m_mode = ST_STEP;
                    m_skip = 1;
                end
            end
        endcase
    endtask

    // One clock: check outputs mid-cycle, then advance model and PC after the edge.
    task automatic tick();
        bit stop, e_pc_we, e_we, e_iflush, e_xflush;
        #1;
        stop = (m_mode == ST_RUN) && (halt_req || (bp_en && pc_r == bp_addr && !m_skip));
        case (m_mode)
            ST_FILL:   begin e_pc_we = 0; e_we = 1; e_iflush = 1; e_xflush = 1; end
            ST_HALTED: begin e_pc_we = 0; e_we = 1; e_iflush = 1; e_xflush = 0; end
            ST_DRAIN: begin
                e_pc_we  = jump_taken;
                e_we     = jump_taken || !load_use;
                e_iflush = 1;
                e_xflush = jump_taken || load_use;
            end
            default: begin
                e_pc_we  = jump_taken || (!stop && !load_use);
                e_we     = jump_taken || !load_use;
                e_iflush = jump_taken || stop;
                e_xflush = jump_taken || load_use;
            end
        endcase
        obs_pc_we      = pc_we;
        obs_ifid_flush = ifid_flush;
        obs_idex_flush = idex_flush;
        obs_state      = state;
        check("state", {29'd0, state}, 32'(m_mode));
        check("stage_en", {27'd0, stage_en}, (32'd1 << m_fill) - 32'd1);
        check("pc_we", {31'd0, pc_we}, {31'd0, e_pc_we});
        check("ifid_we", {31'd0, ifid_we}, {31'd0, e_we});
        check("ifid_flush", {31'd0, ifid_flush}, {31'd0, e_iflush});
        check("idex_flush", {31'd0, idex_flush}, {31'd0, e_xflush});
        check("halted", {31'd0, halted}, {31'd0, m_mode == ST_HALTED});
        check("retire_cnt", retire_cnt, m_retire);
        @(posedge clk);
        #1;
        model_update(stop, e_we, e_iflush, e_xflush);
        if (e_pc_we && rst) pc_r = jump_taken ? jmp_tgt : ((pc_r + 32'd4) & pc_mask);
        @(negedge clk);
    endtask

    initial begin
        int n, pcw;
        rst = 0; run_req = 0; step_req = 0; halt_req = 0; bp_en = 0; load_use = 0;
        jump_taken = 0; bp_addr = 0; pc_r = 0; jmp_tgt = 0; pc_mask = 32'hffff_ffff;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        tick();

        // fill sequence then run into a breakpoint at 0x20
        rst = 1; run_req = 1; bp_en = 1; bp_addr = 32'h20;
        for (int k = 1; k <= NSTAGE; k++) begin
            tick();
            check("fill_seq", {27'd0, stage_en}, (32'd1 << k) - 32'd1);
        end
        check("first_pc_we", {31'd0, pc_we}, 32'd1);
        run_req = 0;
        n = 0;
        while (pc_r != 32'h20 && n < 40) begin tick(); n++; end
        check("reach_bp", {31'd0, n < 40}, 32'd1);
        tick();
        check("bp_pc_we", {31'd0, obs_pc_we}, 32'd0);
        check("bp_ifid_flush", {31'd0, obs_ifid_flush}, 32'd1);
        n = 0;
        while (!halted && n < 20) begin tick(); n++; end
        check("drain_cycles", n, 32'd4);
        exp_q.push_back(32'd8);
        check("retire_at_bp", retire_cnt, exp_q.pop_front());

        // single step over the breakpoint address
        step_req = 1; tick(); step_req = 0;
        n = 0; pcw = 0;
        while (!halted && n < 20) begin tick(); pcw += int'(obs_pc_we); n++; end
        check("step_pc_we_cnt", pcw, 32'd1);
        check("step_halted", {31'd0, halted}, 32'd1);
        exp_q.push_back(32'd9);
        check("retire_after_step", retire_cnt, exp_q.pop_front());

        // resume; load-use and redirect in the same cycle
        run_req = 1; tick(); run_req = 0;
        tick(); tick();
        load_use = 1; jump_taken = 1; jmp_tgt = 32'h100;
        tick();
        check("lu_jmp_pc_we", {31'd0, obs_pc_we}, 32'd1);
        check("lu_jmp_ifid_flush", {31'd0, obs_ifid_flush}, 32'd1);
        check("lu_jmp_idex_flush", {31'd0, obs_idex_flush}, 32'd1);
        load_use = 0; jump_taken = 0;

        // redirect resolving while draining
        repeat (3) tick();
        halt_req = 1; tick(); halt_req = 0;
        jump_taken = 1; jmp_tgt = 32'h200;
        tick();
        check("drain_jmp_state", {29'd0, obs_state}, 32'(ST_DRAIN));
        check("drain_jmp_pc_we", {31'd0, obs_pc_we}, 32'd1);
        jump_taken = 0;
        n = 0;
        while (!halted && n < 20) begin tick(); n++; end
        check("drain_jmp_halted", {31'd0, halted}, 32'd1);

        // reset in the middle of a drain
        rst = 0; tick(); rst = 1; bp_en = 0; run_req = 1;
        n = 0;
        while (state != ST_RUN && n < 20) begin tick(); n++; end
        run_req = 0;
        repeat (8) tick();
        halt_req = 1; tick(); halt_req = 0;
        n = 0;
        while (m_retire != 32'd7 && n < 10) begin tick(); n++; end
        check("pre_rst_retire", retire_cnt, 32'd7);
        check("pre_rst_state", {29'd0, state}, 32'(ST_DRAIN));
        rst = 0; tick(); rst = 1;
        check("rst_state", {29'd0, state}, 32'(ST_FILL));
        check("rst_stage_en", {27'd0, stage_en}, 32'd0);
        check("rst_retire", retire_cnt, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);

        // randomized traffic over a small PC window so breakpoints hit
        pc_r = 0; pc_mask = 32'h3f;
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 99) != 0);
            run_req    = ($urandom_range(0, 3) == 0);
            step_req   = ($urandom_range(0, 5) == 0);
            halt_req   = ($urandom_range(0, 11) == 0);
            load_use   = ($urandom_range(0, 4) == 0);
            jump_taken = ($urandom_range(0, 6) == 0);
            bp_en      = ($urandom_range(0, 1) == 0);
            bp_addr    = $urandom_range(0, 15) * 4;
            jmp_tgt    = $urandom_range(0, 15) * 4;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 32, width of PC and breakpoint address.
REQ-002 SHALL have parameter NSTAGE, default 5, number of pipeline stages (IF, ID, EX, MEM, WB).
REQ-003 SHALL have ports, clock and reset first; all inputs are sampled on clk and all outputs are registered unless noted:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- run_req  in  1  level; request continuous execution.
- step_req  in  1  one-cycle pulse; execute exactly one instruction.
- halt_req  in  1  one-cycle pulse; stop fetching and drain.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint PC.
- pc  in  PC_W  current IF-stage PC.
- load_use  in  1  load-use hazard from ID.
- jump_taken  in  1  redirect (branch/jal/jalr) resolved in EX.
- stage_en  out  NSTAGE  per-stage run enable; bit 0 is IF.
- pc_we  out  1  PC register update enable (combinational).
- ifid_we  out  1  IF/ID register write enable (combinational).
- ifid_flush  out  1  load NOP into IF/ID (combinational).
- idex_flush  out  1  load bubble into ID/EX (combinational).
- halted  out  1  pipeline empty and stopped.
- state  out  3  current FSM state code.
- retire_cnt  out  32  retired instruction count.

Function
REQ-004 SHALL implement states FILL, RUN, DRAIN, HALTED, STEP.
REQ-005 FILL: stage_en SHALL shift in one 1 per cycle (stage_en <= {stage_en, 1}); on the edge stage_en becomes all-ones, state SHALL become RUN.
REQ-006 FILL: pc_we=0, ifid_we=1, ifid_flush=1, idex_flush=1.
REQ-007 RUN, no hazard: pc_we=1, ifid_we=1, both flushes 0.
REQ-008 RUN, load_use=1 and jump_taken=0: pc_we=0, ifid_we=0, idex_flush=1.
REQ-009 RUN, jump_taken=1: pc_we=1, ifid_flush=1, idex_flush=1; jump_taken SHALL win over a simultaneous load_use.
REQ-010 RUN, halt_req=1, or (bp_en and pc==bp_addr and bp_skip=0): same cycle pc_we=0, ifid_flush=1; next state DRAIN. The breakpoint instruction SHALL NOT be fetched.
REQ-011 DRAIN: no new fetch (ifid_flush=1, pc_we=0), except jump_taken=1 SHALL still assert pc_we=1 and idex_flush=1; load_use SHALL still assert idex_flush=1 and ifid_we=0.
REQ-012 SHALL track valid bits v_id, v_ex, v_mem, v_wb:
- v_id loads (ifid_we and not ifid_flush) when ifid_we=1, else holds.
- v_ex loads (v_id and not idex_flush).
- v_mem <= v_ex; v_wb <= v_mem.
REQ-013 DRAIN SHALL go to HALTED on the edge where all valid bits are 0 and jump_taken=0.
REQ-014 HALTED: halted=1, pc_we=0, ifid_flush=1; stage_en stays all-ones.
- halt_req=1: stay in HALTED; halt_req SHALL win over a simultaneous run_req or step_req.
- else run_req=1: go to RUN with bp_skip=1.
- else step_req=1: go to STEP with bp_skip=1.
REQ-015 bp_skip SHALL suppress breakpoint match for exactly the first RUN/STEP cycle, then clear.
REQ-016 STEP: one cycle with the same pc_we/ifid_we/flush rules as RUN; next state DRAIN. If load_use=1, STEP SHALL hold until it is 0. step_req outside HALTED SHALL be ignored.
REQ-017 halt_req during FILL SHALL set a pending flag that forces DRAIN instead of RUN at fill end.
REQ-018 retire_cnt SHALL increment by 1 each cycle v_wb=1, wrapping modulo 2^32.

Reset
REQ-019 When rst=0 at a clock edge: state=FILL, stage_en=0, valid bits=0, bp_skip=0, pending=0, retire_cnt=0, halted=0. Combinational outputs then follow the FILL rules.
REQ-020 Reset asserted in any state SHALL abort the current operation with no further retire counting.

Structure
REQ-021 The state encoding enum and NSTAGE default SHALL live in shared package pipe_ctrl_pkg.
REQ-022 Valid-bit tracking and retire_cnt SHALL be sub-module pipe_valid_track; the FSM and output decode stay in pipe_ctrl.

Verification
REQ-023 Release reset, run_req=1 -> stage_en 00001, 00011, 00111, 01111, 11111 on successive edges; pc_we first 1 in the cycle after stage_en=11111.
REQ-024 RUN, bp_en=1, bp_addr=0x20, pc reaches 0x20 -> pc_we=0 that cycle; halted=1 after 4 drain cycles; retire_cnt equals instructions fetched before 0x20.
REQ-025 HALTED, pc=0x20, single step_req pulse -> exactly one pc_we=1 cycle; halted returns; retire_cnt +1; breakpoint at 0x20 does not re-trigger.
REQ-026 RUN, load_use=1 and jump_taken=1 same cycle -> pc_we=1, ifid_flush=1, idex_flush=1.
REQ-027 DRAIN with jump_taken=1 in EX -> pc_we=1 that cycle; HALTED only after valid bits clear.
REQ-028 rst=0 during DRAIN with retire_cnt=7 -> next edge state=FILL, stage_en=0, retire_cnt=0, halted=0.
